// File: rtl/uart_rx_deserializer.sv
// 8N1 receiver: two-flop line sync, mid-bit sampling FSM, byte buffer with valid/read handshake.
// Optional UART_RX_FIFO_EN selects a FIFO_DEPTH-entry circular buffer instead of one holding register.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 385,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_UART_TX,
  input  logic       i_rx_read,
  input  logic       i_clear_err,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_busy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_rx_deserializer: illegal parameter value");
  end

  // IDLE wait start | START confirm start mid-bit | DATA shift 8 bits | STOP check stop | BREAK wait line high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT);

  state_t      state;
  logic        sync1, rx_s;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic        push, frame_set, overrun_set, pop, full;
  logic [7:0]  push_byte;
  logic        tc;

  assign tc = (cnt == 16'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_UART_TX;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      push      <= 1'b0;
      push_byte <= 8'h00;
      frame_set <= 1'b0;
      o_rx_busy <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_set <= 1'b0;
      case (state)
        S_IDLE: if (!rx_s) begin
          cnt       <= HALF_BIT;
          state     <= S_START;
          o_rx_busy <= 1'b1;
        end
        S_START: if (tc) begin
          if (!rx_s) begin
            cnt   <= FULL_BIT;
            idx   <= 3'd0;
            state <= S_DATA;
          end else begin
            state     <= S_IDLE;
            o_rx_busy <= 1'b0;
          end
        end else cnt <= cnt - 16'd1;
        S_DATA: if (tc) begin
          shift[idx] <= rx_s;
          cnt        <= FULL_BIT;
          if (idx == 3'd7) state <= S_STOP;
          else idx <= idx + 3'd1;
        end else cnt <= cnt - 16'd1;
        S_STOP: if (tc) begin
          if (rx_s) begin
            push      <= 1'b1;
            push_byte <= shift;
            state     <= S_IDLE;
            o_rx_busy <= 1'b0;
          end else begin
            frame_set <= 1'b1;
            state     <= S_BREAK;
          end
        end else cnt <= cnt - 16'd1;
        S_BREAK: if (rx_s) begin
          state     <= S_IDLE;
          o_rx_busy <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          o_rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = i_rx_read && !empty;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign o_rx_valid = !empty;
  assign o_rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
`else
  logic [7:0] hold;
  logic       hold_valid;

  assign full = hold_valid;
  assign pop  = i_rx_read && hold_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold       <= 8'h00;
      hold_valid <= 1'b0;
    end else if (push && (!full || pop)) begin
      hold       <= push_byte;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign o_rx_valid = hold_valid;
  assign o_rx_data  = hold;
`endif

  assign overrun_set = push && full && !pop;

  // Set beats clear when both land on the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (frame_set)        o_frame_err <= 1'b1;
      else if (i_clear_err) o_frame_err <= 1'b0;
      if (overrun_set)      o_overrun   <= 1'b1;
      else if (i_clear_err) o_overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at CLKS_PER_BIT=8; buffer depth follows UART_RX_FIFO_EN.
module tb_uart_rx_deserializer;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       line = 1'b1;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun;

  int total = 0;
  int bad = 0;

  uart_rx_deserializer #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .i_UART_TX(line), .i_rx_read(rd), .i_clear_err(clr),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_rx_busy(rx_busy),
    .o_frame_err(frame_err), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame; optionally pulses the read strobe on the buffer-write edge.
  task automatic send(input logic [7:0] b, input logic stop, input logic pop_on_push);
    line = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (8) tick();
    end
    line = stop;
    repeat (7) tick();
    rd = pop_on_push;
    tick();
    rd = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {7'd0, rx_valid}, 8'd1);
    check({tag, "_data"}, rx_data, exp);
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin : stim
    logic       saw_busy;
    logic [7:0] b;
    logic [7:0] q[$];

    repeat (3) tick();
    check("rst_valid", {7'd0, rx_valid}, 8'd0);
    check("rst_data", rx_data, 8'h00);
    check("rst_busy", {7'd0, rx_busy}, 8'd0);
    check("rst_ferr", {7'd0, frame_err}, 8'd0);
    check("rst_ovr", {7'd0, overrun}, 8'd0);
    reset = 1'b1;
    repeat (4) tick();

    send(8'hA5, 1'b1, 1'b0);
    repeat (2) tick();
    check("single_valid", {7'd0, rx_valid}, 8'd1);
    check("single_data", rx_data, 8'hA5);
    check("single_ferr", {7'd0, frame_err}, 8'd0);
    check("single_ovr", {7'd0, overrun}, 8'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("single_pop_valid", {7'd0, rx_valid}, 8'd0);

    saw_busy = 1'b0;
    line = 1'b0;
    repeat (3) begin tick(); saw_busy |= rx_busy; end
    line = 1'b1;
    repeat (12) begin tick(); saw_busy |= rx_busy; end
    check("glitch_busy_pulse", {7'd0, saw_busy}, 8'd1);
    check("glitch_busy_end", {7'd0, rx_busy}, 8'd0);
    check("glitch_valid", {7'd0, rx_valid}, 8'd0);
    check("glitch_ferr", {7'd0, frame_err}, 8'd0);

    send(8'h3C, 1'b0, 1'b0);
    repeat (40) tick();
    check("frame_err_set", {7'd0, frame_err}, 8'd1);
    check("frame_valid", {7'd0, rx_valid}, 8'd0);
    check("frame_break_busy", {7'd0, rx_busy}, 8'd1);
    line = 1'b1;
    repeat (4) tick();
    check("frame_idle", {7'd0, rx_busy}, 8'd0);
    check("frame_err_sticky", {7'd0, frame_err}, 8'd1);
    pulse_clear();
    check("frame_err_clr", {7'd0, frame_err}, 8'd0);

    for (int i = 0; i <= DEPTH; i++) send(8'(i + 1), 1'b1, 1'b0);
    repeat (2) tick();
    check("ovr_set", {7'd0, overrun}, 8'd1);
    for (int i = 0; i < DEPTH; i++) read_check("ovr_read", 8'(i + 1));
    check("ovr_drained", {7'd0, rx_valid}, 8'd0);
    pulse_clear();
    check("ovr_clr", {7'd0, overrun}, 8'd0);

    for (int i = 0; i < 10; i++) begin
      b = 8'(16 + i);
      if (i < DEPTH) send(b, 1'b1, 1'b0);
      else begin
        check("pp_head", rx_data, q[0]);
        void'(q.pop_front());
        send(b, 1'b1, 1'b1);
      end
      q.push_back(b);
    end
    repeat (2) tick();
    check("pp_no_ovr", {7'd0, overrun}, 8'd0);
    while (q.size() > 0) read_check("pp_read", q.pop_front());
    check("pp_drained", {7'd0, rx_valid}, 8'd0);

    send(8'h77, 1'b1, 1'b0);
    line = 1'b0;
    repeat (8) tick();
    line = 1'b1;
    repeat (36) tick();
    check("mid_busy", {7'd0, rx_busy}, 8'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_valid", {7'd0, rx_valid}, 8'd0);
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_busy", {7'd0, rx_busy}, 8'd0);
    check("mid_rst_ferr", {7'd0, frame_err}, 8'd0);
    check("mid_rst_ovr", {7'd0, overrun}, 8'd0);
    repeat (40) tick();
    check("mid_no_spurious", {7'd0, rx_valid}, 8'd0);
    send(8'h5A, 1'b1, 1'b0);
    repeat (2) tick();
    read_check("after_rst", 8'h5A);
    check("after_rst_ferr", {7'd0, frame_err}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
